figo_seq_detector: RTL and testbench

Parametrised successor to the team's fixed 3-bit serial FSM. It detects a runtime-programmable serial bit pattern of 1..PAT_W bits on a qualified bit stream. Overlapping or non-overlapping matching is selectable, and an optional match limit stops detection once reached. It sits on the serial input path and feeds detect pulses, a match count and a state/progress readback to the control logic.

---
 rtl/figo_seq_detector.sv | 152 +++++++++++++++
 tb/tb_figo_seq_detector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/figo_seq_detector.sv
// Serial pattern detector: runtime-programmable pattern of 1..PAT_W bits,
// overlapping or non-overlapping matching, optional stop after a match limit.
module figo_seq_detector #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             inbit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] fill,
  output logic [1:0]       state_o,
  output logic             cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state_q, state_d;
  // The oldest window bit is shifted out before any compare, so only
  // PAT_W-1 history bits need storage; the newest bit comes from inbit.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             detect_q, detect_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_legal;
  logic [PAT_W-1:0] win_next;
  logic [LEN_W-1:0] fill_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [PAT_W-1:0] len_mask;
  logic             pattern_hit;
  logic             match;

  assign cfg_legal = (cfg_len != '0) && (cfg_len <= FILL_MAX);
  assign win_next  = {hist_q, inbit};
  assign fill_next = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + LEN_W'(1);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end
  endgenerate

  assign pattern_hit = (((win_next ^ pat_q) & len_mask) == '0);
  assign match       = pattern_hit && (fill_next >= len_q);

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    lim_d     = lim_q;
    detect_d  = 1'b0;
    cfg_err_d = 1'b0;

    if (cfg_load) begin
      if (cfg_legal) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        lim_d   = cfg_limit;
        hist_d  = '0;
        fill_d  = '0;
        cnt_d   = '0;
        state_d = ST_RUN;
      end else begin
        cfg_err_d = 1'b1;
        if (state_q == 2'b11) begin
          state_d = ST_IDLE;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (in_valid) begin
            hist_d = win_next[PAT_W-2:0];
            fill_d = fill_next;
            if (match) begin
              detect_d = 1'b1;
              cnt_d    = cnt_inc;
              if (!ovl_q) begin
                fill_d = '0;
              end
              if ((lim_q != '0) && (cnt_inc == lim_q)) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      pat_q     <= '0;
      len_q     <= LEN_W'(1);
      ovl_q     <= 1'b0;
      lim_q     <= '0;
      detect_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      lim_q     <= lim_d;
      detect_q  <= detect_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign detect      = detect_q;
  assign match_count = cnt_q;
  assign fill        = fill_q;
  assign state_o     = state_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_figo_seq_detector.sv
// Scoreboard bench for figo_seq_detector: a bit-history model predicts every
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_figo_seq_detector;

  localparam int PAT_W = 8;
  localparam int CNT_W = 16;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             inbit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_limit;
  logic             detect;
  logic [CNT_W-1:0] match_count;
  logic [LEN_W-1:0] fill;
  logic [1:0]       state_o;
  logic             cfg_err;

  figo_seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .inbit(inbit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit), .detect(detect),
    .match_count(match_count), .fill(fill), .state_o(state_o), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int det;
    int err;
    int cnt;
    int fil;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  int   det_seen = 0;

  // Reference model: keeps the raw received bit history, not a shift register.
  int   m_state, m_fill, m_cnt, m_len, m_lim;
  bit   m_ovl;
  bit   [PAT_W-1:0] m_pat;
  bit   m_hist[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, got, exp);
    end
  endtask

  task automatic model_step(output exp_t e);
    bit ok;
    e.det = 0;
    e.err = 0;
    if (!reset) begin
      m_state = 0; m_fill = 0; m_cnt = 0; m_hist.delete();
      m_pat = '0; m_len = 1; m_ovl = 0; m_lim = 0;
    end else if (cfg_load) begin
      if (int'(cfg_len) >= 1 && int'(cfg_len) <= PAT_W) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
        m_lim = int'(cfg_limit);
        m_hist.delete(); m_fill = 0; m_cnt = 0; m_state = 1;
      end else begin
        e.err = 1;
      end
    end else if (m_state == 1 && in_valid) begin
      m_hist.push_back(inbit);
      if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
      if (m_fill < PAT_W) m_fill++;
      if (m_fill >= m_len) begin
        ok = 1;
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) ok = 0;
        if (ok) begin
          e.det = 1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (!m_ovl) m_fill = 0;
          if (m_lim != 0 && m_cnt == m_lim) m_state = 2;
        end
      end
    end
    e.cnt = m_cnt;
    e.fil = m_fill;
    e.st  = m_state;
  endtask

  task automatic drive(input logic rst, input logic ld, input logic v, input logic b);
    exp_t e;
    exp_t g;
    reset = rst; cfg_load = ld; in_valid = v; inbit = b;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
    g = exp_q.pop_front();
    if (detect) det_seen++;
    check_eq("detect", int'(detect), g.det);
    check_eq("cfg_err", int'(cfg_err), g.err);
    check_eq("match_count", int'(match_count), g.cnt);
    check_eq("fill", int'(fill), g.fil);
    check_eq("state", int'(state_o), g.st);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input int len, input logic ovl, input int lim);
    cfg_pattern = p; cfg_len = LEN_W'(len); cfg_overlap = ovl; cfg_limit = CNT_W'(lim);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b1, bits[n - 1 - i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_limit = '0;
    // 1: reset, then bits in IDLE are ignored
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    det_seen = 0;
    send_bits(32'b111, 3);
    check_eq("t1_state", int'(state_o), 0);
    check_eq("t1_det_total", det_seen, 0);

    // 2: overlapping, pattern 1011
    load(8'h0B, 4, 1'b1, 0);
    det_seen = 0;
    send_bits(32'b1011011, 7);
    check_eq("t2_det_total", det_seen, 2);
    check_eq("t2_count", int'(match_count), 2);
    check_eq("t2_fill", int'(fill), 7);

    // 3: non-overlapping
    load(8'h0B, 4, 1'b0, 0);
    det_seen = 0;
    send_bits(32'b1011011, 7);
    check_eq("t3_det_total", det_seen, 1);
    check_eq("t3_fill", int'(fill), 3);
    send_bits(32'b011, 3);
    check_eq("t3_det_last", int'(detect), 1);
    check_eq("t3_count", int'(match_count), 2);

    // 4: limit of 2 stops detection
    load(8'h0B, 4, 1'b1, 2);
    det_seen = 0;
    send_bits(32'b1011011, 7);
    check_eq("t4_det_at_limit", int'(detect), 1);
    check_eq("t4_state_done", int'(state_o), 2);
    send_bits(32'b1011, 4);
    check_eq("t4_det_total", det_seen, 2);
    check_eq("t4_count_held", int'(match_count), 2);
    load(8'h0B, 4, 1'b1, 0);
    check_eq("t4_rearm_state", int'(state_o), 1);
    check_eq("t4_rearm_count", int'(match_count), 0);

    // 5: illegal lengths are rejected, old config kept
    load(8'h55, 0, 1'b0, 1);
    check_eq("t5_err_len0", int'(cfg_err), 1);
    load(8'h55, 9, 1'b0, 1);
    check_eq("t5_err_len9", int'(cfg_err), 1);
    check_eq("t5_state", int'(state_o), 1);
    det_seen = 0;
    send_bits(32'b1011, 4);
    check_eq("t5_old_match", det_seen, 1);

    // 6: gaps in in_valid, then reset mid-pattern
    load(8'h0B, 4, 1'b1, 0);
    det_seen = 0;
    send_bits(32'b101, 3);
    idle(3);
    send_bits(32'b1, 1);
    check_eq("t6_gap_match", int'(detect), 1);
    send_bits(32'b101, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t6_rst_state", int'(state_o), 0);
    check_eq("t6_rst_fill", int'(fill), 0);
    det_seen = 0;
    send_bits(32'b1, 1);
    check_eq("t6_no_det", det_seen, 0);

    // Boundaries: full-width pattern and fill saturation with len 1
    load(8'hA5, 8, 1'b0, 0);
    send_bits(32'hA5, 8);
    check_eq("b_full_width", int'(detect), 1);
    load(8'h01, 1, 1'b1, 0);
    det_seen = 0;
    send_bits(32'h3FF, 10);
    check_eq("b_len1_dets", det_seen, 10);
    check_eq("b_fill_sat", int'(fill), PAT_W);
    // cfg_load wins over in_valid in the same cycle
    cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1; cfg_limit = '0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("b_load_prio", int'(fill), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cycle);
    $fatal(1, "timeout");
  end

endmodule
